// File: rtl/mips_mmio_bridge.sv
// mips_mmio_bridge: splits the CPU data port between RAM and an MMIO block
// (TX byte FIFO, STATUS, optional CYCLE counter under MIPS_MMIO_CYCLE_COUNTER_EN).
module mips_mmio_bridge #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  cpu_mem_write_en,
    input  logic        cpu_mem_read_en,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_write_data,
    output logic [31:0] cpu_mem_read_data,
    output logic [3:0]  ram_write_en,
    output logic        ram_read_en,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_write_data,
    input  logic [31:0] ram_read_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [15:0] OFF_TX   = 16'h0000;
    localparam logic [15:0] OFF_STAT = 16'h0004;
    localparam logic [15:0] OFF_CYC  = 16'h0008;

    logic          mmio_hit;
    logic [15:0]   off;
    logic          wr_any;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          stat_wr;
    logic          ovf_set;
    logic [31:0]   status;
    logic [31:0]   cyc_val;
    logic [31:0]   mmio_rdata;

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          hit_q;
    logic [31:0]   rd_q;
    logic [7:0]    fifo_mem [FIFO_DEPTH];

    assign mmio_hit = (cpu_mem_addr[31:16] == MMIO_BASE[31:16]);
    assign off      = cpu_mem_addr[15:0];
    assign wr_any   = |cpu_mem_write_en;

    assign ram_write_en   = mmio_hit ? 4'b0000 : cpu_mem_write_en;
    assign ram_read_en    = cpu_mem_read_en & ~mmio_hit;
    assign ram_addr       = cpu_mem_addr;
    assign ram_write_data = cpu_mem_write_data;

    assign tx_valid = (count_q != '0);
    assign tx_data  = fifo_mem[rptr_q];
    assign pop      = tx_valid & tx_ready;

    assign push_req = en & mmio_hit & (off == OFF_TX) & wr_any;
    assign stat_wr  = en & mmio_hit & (off == OFF_STAT) & wr_any;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push_ok  = push_req & ((count_q < DEPTH_C) | pop);
    assign ovf_set  = push_req & ~push_ok;

    assign status = {16'h0000, 8'(count_q), 5'b00000,
                     ovf_q, (count_q == DEPTH_C), (count_q == '0)};

`ifdef MIPS_MMIO_CYCLE_COUNTER_EN
    logic        cyc_wr;
    logic [31:0] cyc_q, cyc_d;

    assign cyc_wr  = en & mmio_hit & (off == OFF_CYC) & wr_any;
    assign cyc_val = cyc_q;

    // Cycle counter: software load wins over the free-running increment.
    always_comb begin
        cyc_d = cyc_q;
        if (en) begin
            cyc_d = cyc_wr ? cpu_mem_write_data : cyc_q + 32'd1;
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end
`else
    assign cyc_val = '0;
`endif

    // MMIO read mux, evaluated every cycle from pre-edge state.
    always_comb begin
        mmio_rdata = '0;
        case (off)
            OFF_STAT: mmio_rdata = status;
            OFF_CYC:  mmio_rdata = cyc_val;
            default:  mmio_rdata = '0;
        endcase
    end

    // FIFO pointer/count and sticky overflow next state; set beats clear.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop) begin
            count_d = count_q - 1'b1;
        end
        ovf_d = ovf_set | (ovf_q & ~stat_wr);
    end

    // FIFO control state and registered MMIO read path.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            hit_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (en) begin
                hit_q <= mmio_hit;
                rd_q  <= mmio_rdata;
            end
        end
    end

    // FIFO storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            fifo_mem[wptr_q] <= cpu_mem_write_data[7:0];
        end
    end

    assign cpu_mem_read_data = hit_q ? rd_q : ram_read_data;

endmodule

// File: tb/tb_mips_mmio_bridge.sv
// tb_mips_mmio_bridge: directed and random stimulus against a queue-based
// reference model; a negedge monitor pops per-cycle expectations and compares.
module tb_mips_mmio_bridge;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, en, cpu_mem_read_en, tx_ready;
    logic [3:0]  cpu_mem_write_en;
    logic [31:0] cpu_mem_addr, cpu_mem_write_data;
    logic [31:0] cpu_mem_read_data, ram_addr, ram_write_data;
    logic [3:0]  ram_write_en;
    logic        ram_read_en, tx_valid;
    logic [7:0]  tx_data;
    logic [31:0] ram_rd;

    always #5 clk = ~clk;

    mips_mmio_bridge #(.FIFO_DEPTH(DEPTH), .MMIO_BASE(32'hFFFF_0000)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cpu_mem_write_en(cpu_mem_write_en),
        .cpu_mem_read_en(cpu_mem_read_en),
        .cpu_mem_addr(cpu_mem_addr),
        .cpu_mem_write_data(cpu_mem_write_data),
        .cpu_mem_read_data(cpu_mem_read_data),
        .ram_write_en(ram_write_en), .ram_read_en(ram_read_en),
        .ram_addr(ram_addr), .ram_write_data(ram_write_data),
        .ram_read_data(ram_rd),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    // Bench RAM: 16 words, byte strobes, one-cycle registered read.
    logic [31:0] ram [16];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_write_en[b]) ram[ram_addr[5:2]][8*b +: 8] <= ram_write_data[8*b +: 8];
        ram_rd <= ram[ram_addr[5:2]];
    end

    typedef struct {
        logic        known;
        logic        rd_chk;
        logic [31:0] rd;
        logic        lit_en;
        logic [31:0] lit;
        logic [3:0]  we;
        logic        re;
        logic [31:0] a;
        logic [31:0] wd;
        logic        txv;
        logic [7:0]  txd;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [7:0]  mq[$];
    logic        m_ovf = 1'b0;
    logic [31:0] m_cyc = '0;
    logic        m_hit = 1'b0;
    logic [31:0] m_val = '0;
    logic [31:0] m_prev = '0;
    logic        m_prev_ok = 1'b0;
    logic [31:0] mmem [16];
    logic        mvalid [16];
    logic        known = 1'b0;
    logic        lit_en_n = 1'b0;
    logic [31:0] lit_n = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ram_write_en", 32'(ram_write_en), 32'(e.we));
            chk("ram_read_en", 32'(ram_read_en), 32'(e.re));
            chk("ram_addr", ram_addr, e.a);
            chk("ram_write_data", ram_write_data, e.wd);
            if (e.known) begin
                chk("tx_valid", 32'(tx_valid), 32'(e.txv));
                if (e.txv) chk("tx_data", 32'(tx_data), 32'(e.txd));
            end
            if (e.rd_chk) chk("read_data", cpu_mem_read_data, e.rd);
            if (e.lit_en) chk("read_literal", cpu_mem_read_data, e.lit);
        end
    end

    task automatic lit(input logic [31:0] v);
        lit_en_n = 1'b1;
        lit_n = v;
    endtask

    task automatic step(input logic r, input logic e, input logic [3:0] w,
                        input logic re, input logic [31:0] a,
                        input logic [31:0] wd, input logic rdy);
        exp_t        x;
        logic        hit, pop, push, clr;
        logic [15:0] off;
        logic [31:0] mv;
        int          sz;
        rst = r; en = e; cpu_mem_write_en = w; cpu_mem_read_en = re;
        cpu_mem_addr = a; cpu_mem_write_data = wd; tx_ready = rdy;
        hit = (a[31:16] == 16'hFFFF);
        off = a[15:0];
        sz  = mq.size();
        x.known  = known;
        x.a      = a;
        x.wd     = wd;
        x.we     = hit ? 4'b0000 : w;
        x.re     = re & ~hit;
        x.txv    = (sz != 0);
        x.txd    = (sz != 0) ? mq[0] : 8'h00;
        x.rd_chk = known && (m_hit || m_prev_ok);
        x.rd     = m_hit ? m_val : m_prev;
        x.lit_en = lit_en_n;
        x.lit    = lit_n;
        lit_en_n = 1'b0;
        exp_q.push_back(x);
        // Model the clock edge.
        m_prev    = mmem[a[5:2]];
        m_prev_ok = mvalid[a[5:2]];
        if (!hit) begin
            for (int b = 0; b < 4; b++)
                if (w[b]) mmem[a[5:2]][8*b +: 8] = wd[8*b +: 8];
            if (w == 4'hF) mvalid[a[5:2]] = 1'b1;
        end
        if (r) begin
            mq.delete();
            m_ovf = 1'b0; m_cyc = '0; m_hit = 1'b0; m_val = '0;
            known = 1'b1;
        end else begin
            mv = '0;
            if (hit && off == 16'h0004)
                mv = {16'h0, 8'(sz), 5'h0, m_ovf, sz == DEPTH, sz == 0};
`ifdef MIPS_MMIO_CYCLE_COUNTER_EN
            if (hit && off == 16'h0008) mv = m_cyc;
            if (e) m_cyc = (hit && off == 16'h0008 && w != 0) ? wd : m_cyc + 32'd1;
`endif
            pop  = (sz != 0) && rdy;
            push = e && hit && off == 16'h0000 && w != 0;
            clr  = e && hit && off == 16'h0004 && w != 0;
            if (e) begin m_hit = hit; m_val = mv; end
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (sz < DEPTH || pop) mq.push_back(wd[7:0]);
                else begin m_ovf = 1'b1; clr = 1'b0; end
            end
            if (clr) m_ovf = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] w, input logic rdy);
        step(1'b0, 1'b1, w, 1'b0, a, d, rdy);
    endtask

    task automatic rd(input logic [31:0] a, input logic rdy);
        step(1'b0, 1'b1, 4'h0, 1'b1, a, 32'h0, rdy);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b1, 4'h0, 1'b0, 32'h0000_0040, 32'h0, rdy);
    endtask

    logic        rr, re_r, e_r, rdy_r;
    logic [3:0]  rw;
    logic [31:0] ra, rwd;
    logic [15:0] roff;

    initial begin
        for (int i = 0; i < 16; i++) begin mmem[i] = '0; mvalid[i] = 1'b0; end
        rst = 1'b1; en = 1'b0; cpu_mem_write_en = '0; cpu_mem_read_en = 1'b0;
        cpu_mem_addr = '0; cpu_mem_write_data = '0; tx_ready = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b1, 4'h0, 1'b0, 32'hFFFF_0010, 32'h0, 1'b0);
        step(1'b1, 1'b1, 4'h0, 1'b0, 32'hFFFF_0010, 32'h0, 1'b0);
        for (int i = 0; i < 16; i++) sw(32'(i * 4), $urandom, 4'hF, 1'b0);

        // Single byte store then STATUS.
        sw(32'hFFFF_0000, 32'h4141_4141, 4'b1000, 1'b0);
        rd(32'hFFFF_0004, 1'b0);
        lit(32'h0000_0100);
        idle(1'b0);
        repeat (2) idle(1'b1);

        // Overflow on the ninth push, drain, clear.
        for (int i = 0; i < 9; i++) sw(32'hFFFF_0000, 32'(i), 4'b0001, 1'b0);
        rd(32'hFFFF_0004, 1'b0);
        lit(32'h0000_0806);
        idle(1'b0);
        repeat (8) idle(1'b1);
        sw(32'hFFFF_0004, 32'h0, 4'hF, 1'b0);
        rd(32'hFFFF_0004, 1'b0);
        lit(32'h0000_0001);
        idle(1'b0);

        // Push into a full FIFO while it pops.
        for (int i = 0; i < 8; i++) sw(32'hFFFF_0000, 32'(8'h10 + i), 4'b0001, 1'b0);
        sw(32'hFFFF_0000, 32'h0000_00AA, 4'b0001, 1'b1);
        rd(32'hFFFF_0004, 1'b0);
        lit(32'h0000_0802);
        idle(1'b0);
        repeat (9) idle(1'b1);

        // RAM store/load and an MMIO store to an unmapped offset.
        sw(32'h0000_0100, 32'h1234_5678, 4'hF, 1'b0);
        rd(32'h0000_0100, 1'b0);
        lit(32'h1234_5678);
        idle(1'b0);
        sw(32'hFFFF_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
        rd(32'hFFFF_0010, 1'b0);
        lit(32'h0);
        idle(1'b0);

        // Cycle counter wrap and freeze.
        sw(32'hFFFF_0008, 32'hFFFF_FFFE, 4'hF, 1'b0);
        rd(32'hFFFF_0008, 1'b0);
`ifdef MIPS_MMIO_CYCLE_COUNTER_EN
        lit(32'hFFFF_FFFE);
        rd(32'hFFFF_0008, 1'b0);
        lit(32'hFFFF_FFFF);
        rd(32'hFFFF_0008, 1'b0);
        for (int i = 0; i < 5; i++) begin
            lit(32'h0);
            step(1'b0, 1'b0, 4'h0, 1'b1, 32'hFFFF_0008, 32'h0, 1'b0);
        end
        lit(32'h0);
        rd(32'hFFFF_0008, 1'b0);
        lit(32'h1);
        idle(1'b0);
`else
        lit(32'h0);
        idle(1'b0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rr    = ($urandom_range(0, 299) == 0);
            e_r   = ($urandom_range(0, 7) != 0);
            re_r  = $urandom_range(0, 1) == 1;
            rdy_r = ($urandom_range(0, 2) == 0);
            rwd   = $urandom;
            case ($urandom_range(0, 5))
                0: rw = 4'h0;
                1: rw = 4'hF;
                2: rw = 4'h8;
                3: rw = 4'h4;
                4: rw = 4'h2;
                default: rw = 4'h1;
            endcase
            case ($urandom_range(0, 6))
                0, 1, 2: roff = 16'h0000;
                3: roff = 16'h0004;
                4: roff = 16'h0008;
                5: roff = 16'h000C;
                default: roff = 16'($urandom);
            endcase
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: ra = {16'hFFFF, roff};
                9: ra = {16'hFFFE, roff};
                default: ra = {16'($urandom_range(0, 32'hFFFD)), 16'($urandom)};
            endcase
            step(rr, e_r, rw, re_r, ra, rwd, rdy_r);
        end
        idle(1'b0);

        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
